// File: rtl/alu_seq.sv
// Multi-cycle LC-3b style ALU with valid/ready request and response channels.
// Optional iterative multiplier (op 8) is built only when ALU_MUL_EN is defined.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic [2:0]       resp_nzp,
  output logic             resp_err
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_data;
  logic             r_err;
  logic             r_valid;
  logic [CW-1:0]    r_cnt;

  logic             w_accept;
  logic [SHW-1:0]   w_amt;
  logic             w_is_shift;
  logic             w_is_mul;
  logic             w_multi;
  logic             w_last;
  logic [WIDTH-1:0] w_res;
  logic             w_err;

  function automatic logic [WIDTH-1:0] shift1(input logic [3:0] op, input logic [WIDTH-1:0] v);
    case (op)
      4'd5:    shift1 = {v[WIDTH-2:0], 1'b0};
      4'd6:    shift1 = {1'b0, v[WIDTH-1:1]};
      default: shift1 = {v[WIDTH-1], v[WIDTH-1:1]};
    endcase
  endfunction

  assign w_accept   = req_valid && (r_state == S_IDLE);
  assign w_amt      = req_b[SHW-1:0];
  assign w_is_shift = (req_op == 4'd5) || (req_op == 4'd6) || (req_op == 4'd7);
`ifdef ALU_MUL_EN
  assign w_is_mul   = (req_op == 4'd8);
`else
  assign w_is_mul   = 1'b0;
`endif
  assign w_multi    = (w_is_shift && (w_amt != '0)) || w_is_mul;
  assign w_last     = (r_cnt == CW'(1));

  // Single-cycle results; shifts load a unshifted, mul starts from a zero accumulator
  always_comb begin
    w_res = '0;
    w_err = 1'b0;
    case (req_op)
      4'd0:                w_res = req_a + req_b;
      4'd1:                w_res = req_a & req_b;
      4'd2:                w_res = ~req_a;
      4'd3:                w_res = req_a;
      4'd4:                w_res = req_b;
      4'd5, 4'd6, 4'd7:    w_res = req_a;
`ifdef ALU_MUL_EN
      4'd8:                w_res = '0;
`endif
      default:             w_err = 1'b1;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = w_multi ? S_EXEC : S_DONE;
      S_EXEC:  if (w_last) w_next = S_DONE;
      S_DONE:  if (resp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      r_valid <= (w_next == S_DONE);
    end
  end

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mcand  <= req_a;
      r_mplier <= req_b;
    end else if (r_state == S_EXEC) begin
      r_mcand  <= {r_mcand[WIDTH-2:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
    end
  end
`endif

  // r_data doubles as the shift working register and the mul accumulator
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op   <= '0;
      r_data <= '0;
      r_err  <= 1'b0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_op   <= req_op;
      r_data <= w_res;
      r_err  <= w_err;
      r_cnt  <= w_is_mul ? CW'(WIDTH) : {1'b0, w_amt};
    end else if (r_state == S_EXEC) begin
      r_cnt <= r_cnt - CW'(1);
`ifdef ALU_MUL_EN
      if (r_op == 4'd8) begin
        if (r_mplier[0]) r_data <= r_data + r_mcand;
      end else begin
        r_data <= shift1(r_op, r_data);
      end
`else
      r_data <= shift1(r_op, r_data);
`endif
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = r_valid;
  assign resp_data  = r_data;
  assign resp_err   = r_err;
  assign resp_nzp   = (r_data == '0)     ? 3'b010 :
                      r_data[WIDTH-1]    ? 3'b100 : 3'b001;
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases plus randomized ops against a
// behavioural model; honours ALU_MUL_EN the same way as the design.
module tb_alu_seq;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         req_valid;
  logic         req_ready;
  logic [3:0]   req_op;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         resp_valid;
  logic         resp_ready;
  logic [W-1:0] resp_data;
  logic [2:0]   resp_nzp;
  logic         resp_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_nzp   (resp_nzp),
    .resp_err   (resp_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] d, output logic e, output int lat);
    int      amt;
    longint  prod;
    amt  = int'(b) % W;
    d    = '0;
    e    = 1'b0;
    lat  = 1;
    prod = 0;
    case (op)
      0: d = a + b;
      1: d = a & b;
      2: d = ~a;
      3: d = a;
      4: d = b;
      5: begin d = a << amt; lat = 1 + amt; end
      6: begin d = a >> amt; lat = 1 + amt; end
      7: begin d = $signed(a) >>> amt; lat = 1 + amt; end
`ifdef ALU_MUL_EN
      8: begin prod = longint'(a) * longint'(b); d = prod[W-1:0]; lat = 1 + W; end
`endif
      default: e = 1'b1;
    endcase
  endfunction

  function automatic logic [2:0] nzp_of(input logic [W-1:0] d);
    if (d == 0)              return 3'b010;
    else if ($signed(d) < 0) return 3'b100;
    else                     return 3'b001;
  endfunction

  task automatic run_op(input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, input string tag);
    logic [W-1:0] ed;
    logic         ee;
    int           el;
    int           lat;
    logic [W-1:0] held;
    model(op, a, b, ed, ee, el);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 4'(op);
    req_a     = a;
    req_b     = b;
    check({tag, ":req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ":latency"}, 32'(lat), 32'(el));
    check({tag, ":data"}, 32'(resp_data), 32'(ed));
    check({tag, ":err"}, 32'(resp_err), 32'(ee));
    check({tag, ":nzp"}, 32'(resp_nzp), 32'(nzp_of(ed)));
    held = resp_data;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      req_op    = 4'd4;
      req_b     = ~held;
      @(negedge clk);
      check({tag, ":hold_data"}, 32'(resp_data), 32'(held));
      check({tag, ":hold_valid"}, 32'(resp_valid), 32'd1);
      check({tag, ":hold_ready"}, 32'(req_ready), 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, ":post_valid"}, 32'(resp_valid), 32'd0);
    check({tag, ":post_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_op     = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    #2;
    check("reset:resp_valid", 32'(resp_valid), 32'd0);
    check("reset:req_ready", 32'(req_ready), 32'd1);
    check("reset:data", 32'(resp_data), 32'd0);
    check("reset:nzp", 32'(resp_nzp), 32'b010);
    check("reset:err", 32'(resp_err), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    run_op(0, 16'h7FFF, 16'h0001, 0, "add_ovf");
    run_op(7, 16'h8000, 16'h0003, 0, "sra3");
    run_op(5, 16'h1234, 16'h0010, 0, "sll0");
    run_op(8, 16'h0123, 16'h0011, 0, "mul");
    run_op(1, 16'hF0F0, 16'h0FF0, 5, "and_bp");
    run_op(15, 16'hFFFF, 16'h0000, 0, "illegal");
    run_op(0, 16'h0001, 16'h0002, 0, "after_illegal");
    run_op(2, 16'h0000, 16'h0000, 1, "not0");
    run_op(6, 16'h8001, 16'h000F, 0, "srl15");

    // Reset pulsed while a long shift is still iterating
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 4'd6;
    req_a     = 16'hFFFF;
    req_b     = 16'h000F;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("midrst:resp_valid", 32'(resp_valid), 32'd0);
    check("midrst:req_ready", 32'(req_ready), 32'd1);
    check("midrst:data", 32'(resp_data), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check("midrst:no_resp", 32'(resp_valid), 32'd0);
    end
    run_op(4, 16'hFFFF, 16'h0000, 0, "rst_passb");

    for (int k = 0; k < 150; k++) begin
      int           op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      op = $urandom_range(0, 15);
      if (k % 3 == 0) op = $urandom_range(5, 8);
      a = W'($urandom);
      b = W'($urandom);
      run_op(op, a, b, $urandom_range(0, 2), $sformatf("rand%0d_op%0d", k, op));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
